// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-setting path: FSM states, field codes,
// reset date and the 52-bit packed time layout used on cur_time/bin_time.
package watch_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ED_YR,
        S_ED_MON,
        S_ED_DAY,
        S_ED_HR,
        S_ED_MIN,
        S_ED_SEC,
        S_COMMIT
    } state_t;

    localparam logic [2:0] FLD_YR  = 3'd0;
    localparam logic [2:0] FLD_MON = 3'd1;
    localparam logic [2:0] FLD_DAY = 3'd2;
    localparam logic [2:0] FLD_HR  = 3'd3;
    localparam logic [2:0] FLD_MIN = 3'd4;
    localparam logic [2:0] FLD_SEC = 3'd5;

    localparam logic [11:0] RST_YEAR  = 12'd2021;
    localparam logic [7:0]  RST_MONTH = 8'd5;
    localparam logic [7:0]  RST_DAY   = 8'd30;

    localparam int OFF_SEC = 0;
    localparam int OFF_MIN = 8;
    localparam int OFF_HR  = 16;
    localparam int OFF_DAY = 24;
    localparam int OFF_MON = 32;
    localparam int OFF_YR  = 40;

    typedef struct packed {
        logic [11:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  second;
    } time_t;

    localparam time_t RST_TIME = {RST_YEAR, RST_MONTH, RST_DAY, 8'd0, 8'd0, 8'd0};

    function automatic logic [2:0] field_of(input state_t s);
        case (s)
            S_ED_MON: return FLD_MON;
            S_ED_DAY: return FLD_DAY;
            S_ED_HR:  return FLD_HR;
            S_ED_MIN: return FLD_MIN;
            S_ED_SEC: return FLD_SEC;
            default:  return FLD_YR;
        endcase
    endfunction

endpackage

// File: rtl/watch_days_in_month.sv
// Combinational month length with Gregorian leap-year rule; zero latency, no handshake.
module watch_days_in_month (
    input  logic [7:0]  month,
    input  logic [11:0] year,
    output logic [7:0]  max_day
);

    logic leap;

    always_comb begin
        leap = ((year % 12'd4 == 12'd0) && (year % 12'd100 != 12'd0)) ||
               (year % 12'd400 == 12'd0);
        case (month)
            8'd2:                    max_day = leap ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: max_day = 8'd30;
            default:                 max_day = 8'd31;
        endcase
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Key-driven time editor: snapshots cur_time, edits one field at a time, commits via set_time.
// btn_ok -> set_time is 1 clk; keys are single-cycle pulses with no backpressure.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int TIMEOUT_SEC = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_ok,
    input  logic [51:0] cur_time,
    output logic        set_time,
    output logic [51:0] bin_time,
    output logic        edit_active,
    output logic [2:0]  edit_field,
    output logic        blink
);

    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    state_t        state, state_nxt;
    time_t         shadow, shadow_nxt, shadow_view, committed;
    logic [7:0]    max_day, day_clamped;
    logic [TW-1:0] to_cnt;
    logic          editing, any_key, timeout, step_up, step_dn;

    watch_days_in_month u_dim (
        .month   (shadow.month),
        .year    (shadow.year),
        .max_day (max_day)
    );

    assign editing     = (state >= S_ED_YR) && (state <= S_ED_SEC);
    assign any_key     = btn_mode | btn_up | btn_down | btn_ok;
    assign timeout     = clk1sec && !any_key && (to_cnt == TW'(TIMEOUT_SEC - 1));
    assign step_up     = btn_up & ~btn_down & ~btn_ok & ~btn_mode;
    assign step_dn     = btn_down & ~btn_up & ~btn_ok & ~btn_mode;
    assign day_clamped = (shadow.day > max_day) ? max_day : shadow.day;
    assign edit_active = (state != S_IDLE);

    always_comb begin
        shadow_view     = shadow;
        shadow_view.day = day_clamped;
    end

    // Outside an edit the display shows what watch_time was last loaded with.
    assign bin_time = (state == S_IDLE || state == S_LOAD) ? committed : shadow_view;

    always_comb begin
        state_nxt  = state;
        set_time   = 1'b0;
        edit_field = FLD_YR;
        case (state)
            S_IDLE:   if (btn_mode) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_ED_YR;
            S_COMMIT: begin
                set_time  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ED_YR, S_ED_MON, S_ED_DAY, S_ED_HR, S_ED_MIN, S_ED_SEC: begin
                edit_field = field_of(state);
                if (btn_ok)
                    state_nxt = S_COMMIT;
                else if (btn_mode)
                    state_nxt = (state == S_ED_SEC) ? S_ED_YR : state_t'(state + 4'd1);
                else if (timeout)
                    state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Edits start from the clamped day so a wrap never sees an out-of-range value.
    always_comb begin
        shadow_nxt = shadow;
        if (state == S_LOAD) begin
            shadow_nxt = cur_time;
        end else if (editing) begin
            shadow_nxt.day = day_clamped;
            if (step_up) begin
                case (state)
                    S_ED_YR:  shadow_nxt.year   = (shadow.year >= 12'd4095) ? 12'd1 : shadow.year + 12'd1;
                    S_ED_MON: shadow_nxt.month  = (shadow.month >= 8'd12) ? 8'd1 : shadow.month + 8'd1;
                    S_ED_DAY: shadow_nxt.day    = (day_clamped >= max_day) ? 8'd1 : day_clamped + 8'd1;
                    S_ED_HR:  shadow_nxt.hour   = (shadow.hour >= 8'd23) ? 8'd0 : shadow.hour + 8'd1;
                    S_ED_MIN: shadow_nxt.minute = (shadow.minute >= 8'd59) ? 8'd0 : shadow.minute + 8'd1;
                    S_ED_SEC: shadow_nxt.second = (shadow.second >= 8'd59) ? 8'd0 : shadow.second + 8'd1;
                    default:  shadow_nxt = shadow;
                endcase
            end else if (step_dn) begin
                case (state)
                    S_ED_YR:  shadow_nxt.year   = (shadow.year <= 12'd1) ? 12'd4095 : shadow.year - 12'd1;
                    S_ED_MON: shadow_nxt.month  = (shadow.month <= 8'd1) ? 8'd12 : shadow.month - 8'd1;
                    S_ED_DAY: shadow_nxt.day    = (day_clamped <= 8'd1) ? max_day : day_clamped - 8'd1;
                    S_ED_HR:  shadow_nxt.hour   = (shadow.hour == 8'd0) ? 8'd23 : shadow.hour - 8'd1;
                    S_ED_MIN: shadow_nxt.minute = (shadow.minute == 8'd0) ? 8'd59 : shadow.minute - 8'd1;
                    S_ED_SEC: shadow_nxt.second = (shadow.second == 8'd0) ? 8'd59 : shadow.second - 8'd1;
                    default:  shadow_nxt = shadow;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shadow    <= RST_TIME;
            committed <= RST_TIME;
            to_cnt    <= '0;
            blink     <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            if (state == S_COMMIT)
                committed <= shadow_view;
            if (!editing || any_key)
                to_cnt <= '0;
            else if (clk1sec)
                to_cnt <= to_cnt + 1'b1;
            if (state_nxt == S_IDLE || state_nxt == S_LOAD)
                blink <= 1'b0;
            else if (editing && clk1sec)
                blink <= ~blink;
        end
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl: vector table for single-cycle behaviour,
// hand sequences for calendar clamp, timeout and mid-edit reset.
module tb_watch_set_ctrl;
    import watch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk1sec = 1'b0;
    logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_ok = 1'b0;
    logic [51:0] cur_time = '0;
    logic        set_time;
    logic [51:0] bin_time;
    logic        edit_active;
    logic [2:0]  edit_field;
    logic        blink;

    int n_chk  = 0;
    int n_fail = 0;
    int n_sets = 0;

    watch_set_ctrl #(.TIMEOUT_SEC(30)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk1sec     (clk1sec),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_ok      (btn_ok),
        .cur_time    (cur_time),
        .set_time    (set_time),
        .bin_time    (bin_time),
        .edit_active (edit_active),
        .edit_field  (edit_field),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (set_time) n_sets++;

    typedef struct {
        logic        mode, up, down, ok, tick;
        logic [51:0] cur;
        logic        act;
        logic [2:0]  fld;
        logic        set;
        logic        blk;
        logic [51:0] bin;
    } vec_t;

    vec_t vt[$];

    function automatic logic [51:0] mk(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        logic [51:0] r;
        r = '0;
        r[OFF_YR  +: 12] = y[11:0];
        r[OFF_MON +: 8]  = mo[7:0];
        r[OFF_DAY +: 8]  = d[7:0];
        r[OFF_HR  +: 8]  = h[7:0];
        r[OFF_MIN +: 8]  = mi[7:0];
        r[OFF_SEC +: 8]  = s[7:0];
        return r;
    endfunction

    task automatic av(input logic m, input logic u, input logic d, input logic o, input logic t,
                      input logic [51:0] c, input logic a, input logic [2:0] f, input logic s,
                      input logic b, input logic [51:0] bn);
        vec_t v;
        v.mode = m; v.up = u; v.down = d; v.ok = o; v.tick = t; v.cur = c;
        v.act = a; v.fld = f; v.set = s; v.blk = b; v.bin = bn;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [51:0] got, input logic [51:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input logic m, input logic u, input logic d, input logic o, input logic t);
        btn_mode = m; btn_up = u; btn_down = d; btn_ok = o; clk1sec = t;
        @(posedge clk);
        #1;
        btn_mode = 0; btn_up = 0; btn_down = 0; btn_ok = 0; clk1sec = 0;
    endtask

    logic [51:0] R, C1, C2, D1, E1;
    int s0;

    initial begin
        R  = mk(2021, 5, 30, 0, 0, 0);
        C1 = mk(2021, 5, 30, 10, 0, 0);
        C2 = mk(4095, 1, 1, 0, 0, 59);
        D1 = mk(4095, 12, 1, 23, 59, 0);

        //  m  u  d  o  t  cur  act fld set blk bin
        av(0, 0, 0, 0, 0, C1, 0, 0, 0, 0, R);
        av(0, 1, 0, 0, 1, C1, 0, 0, 0, 0, R);
        av(1, 0, 0, 0, 0, C1, 1, 0, 0, 0, R);
        av(0, 0, 0, 0, 0, C1, 1, 0, 0, 0, C1);
        av(1, 0, 0, 0, 0, C1, 1, 1, 0, 0, C1);
        av(1, 0, 0, 0, 0, C1, 1, 2, 0, 0, C1);
        av(0, 0, 1, 0, 0, C1, 1, 2, 0, 0, mk(2021, 5, 29, 10, 0, 0));
        av(0, 0, 1, 0, 0, C1, 1, 2, 0, 0, mk(2021, 5, 28, 10, 0, 0));
        av(0, 0, 1, 0, 0, C1, 1, 2, 0, 0, mk(2021, 5, 27, 10, 0, 0));
        av(0, 0, 0, 1, 0, C1, 1, 0, 1, 0, mk(2021, 5, 27, 10, 0, 0));
        av(0, 0, 0, 0, 0, C1, 0, 0, 0, 0, mk(2021, 5, 27, 10, 0, 0));
        av(1, 0, 0, 0, 0, C2, 1, 0, 0, 0, mk(2021, 5, 27, 10, 0, 0));
        av(0, 0, 0, 0, 0, C2, 1, 0, 0, 0, C2);
        av(0, 1, 0, 0, 0, C2, 1, 0, 0, 0, mk(1, 1, 1, 0, 0, 59));
        av(0, 0, 1, 0, 0, C2, 1, 0, 0, 0, mk(4095, 1, 1, 0, 0, 59));
        av(1, 0, 0, 0, 0, C2, 1, 1, 0, 0, mk(4095, 1, 1, 0, 0, 59));
        av(0, 0, 1, 0, 0, C2, 1, 1, 0, 0, mk(4095, 12, 1, 0, 0, 59));
        av(0, 1, 0, 0, 0, C2, 1, 1, 0, 0, mk(4095, 1, 1, 0, 0, 59));
        av(0, 0, 1, 0, 0, C2, 1, 1, 0, 0, mk(4095, 12, 1, 0, 0, 59));
        av(1, 0, 0, 0, 0, C2, 1, 2, 0, 0, mk(4095, 12, 1, 0, 0, 59));
        av(0, 0, 1, 0, 0, C2, 1, 2, 0, 0, mk(4095, 12, 31, 0, 0, 59));
        av(0, 1, 0, 0, 0, C2, 1, 2, 0, 0, mk(4095, 12, 1, 0, 0, 59));
        av(1, 0, 0, 0, 0, C2, 1, 3, 0, 0, mk(4095, 12, 1, 0, 0, 59));
        av(0, 0, 1, 0, 0, C2, 1, 3, 0, 0, mk(4095, 12, 1, 23, 0, 59));
        av(0, 1, 0, 0, 0, C2, 1, 3, 0, 0, mk(4095, 12, 1, 0, 0, 59));
        av(0, 0, 1, 0, 0, C2, 1, 3, 0, 0, mk(4095, 12, 1, 23, 0, 59));
        av(1, 0, 0, 0, 0, C2, 1, 4, 0, 0, mk(4095, 12, 1, 23, 0, 59));
        av(0, 0, 1, 0, 1, C2, 1, 4, 0, 1, mk(4095, 12, 1, 23, 59, 59));
        av(1, 0, 0, 0, 0, C2, 1, 5, 0, 1, mk(4095, 12, 1, 23, 59, 59));
        av(0, 1, 0, 0, 0, C2, 1, 5, 0, 1, D1);
        av(0, 0, 1, 0, 0, C2, 1, 5, 0, 1, mk(4095, 12, 1, 23, 59, 59));
        av(0, 1, 0, 0, 0, C2, 1, 5, 0, 1, D1);
        av(0, 1, 1, 0, 0, C2, 1, 5, 0, 1, D1);
        av(1, 1, 0, 0, 0, C2, 1, 0, 0, 1, D1);
        av(1, 0, 1, 0, 0, C2, 1, 1, 0, 1, D1);
        av(0, 1, 0, 1, 0, C2, 1, 0, 1, 1, D1);
        av(0, 0, 0, 0, 0, C2, 0, 0, 0, 0, D1);

        #12;
        chk("reset edit_active", 52'(edit_active), 52'd0);
        chk("reset set_time",    52'(set_time),    52'd0);
        chk("reset edit_field",  52'(edit_field),  52'd0);
        chk("reset blink",       52'(blink),       52'd0);
        chk("reset bin_time",    bin_time,         R);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            cur_time = vt[i].cur;
            step(vt[i].mode, vt[i].up, vt[i].down, vt[i].ok, vt[i].tick);
            chk($sformatf("v%0d edit_active", i), 52'(edit_active), 52'(vt[i].act));
            chk($sformatf("v%0d edit_field", i),  52'(edit_field),  52'(vt[i].fld));
            chk($sformatf("v%0d set_time", i),    52'(set_time),    52'(vt[i].set));
            chk($sformatf("v%0d blink", i),       52'(blink),       52'(vt[i].blk));
            chk($sformatf("v%0d bin_time", i),    bin_time,         vt[i].bin);
        end

        // Month change to February clamps the day; year change re-clamps for non-leap.
        cur_time = mk(2024, 1, 31, 12, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("feb 2024 clamp", bin_time, mk(2024, 2, 29, 12, 0, 0));
        chk("feb 2024 day reg", 52'(dut.shadow.day), 52'd29);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
        chk("mode wrap to year", 52'(edit_field), 52'd0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("feb 2025 clamp", bin_time, mk(2025, 2, 28, 12, 0, 0));
        step(0, 0, 0, 1, 0);
        chk("commit 2025 set_time", 52'(set_time), 52'd1);
        chk("commit 2025 bin", bin_time, mk(2025, 2, 28, 12, 0, 0));
        step(0, 0, 0, 0, 0);

        cur_time = mk(2100, 2, 29, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("feb 2100 non-leap", bin_time, mk(2100, 2, 28, 0, 0, 0));
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        cur_time = mk(2000, 2, 29, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("feb 2000 leap", bin_time, mk(2000, 2, 29, 0, 0, 0));
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        E1 = mk(2000, 2, 29, 0, 0, 0);
        chk("committed 2000", bin_time, E1);

        // Day 1 down in April wraps to 30, then the edit is abandoned by timeout.
        cur_time = mk(2023, 4, 1, 6, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("apr day wrap", bin_time, mk(2023, 4, 30, 6, 0, 0));
        s0 = n_sets;
        for (int k = 0; k < 30; k++) begin
            step(0, 0, 0, 0, 1);
            if (k == 28) chk("before timeout active", 52'(edit_active), 52'd1);
            step(0, 0, 0, 0, 0);
        end
        chk("timeout edit_active", 52'(edit_active), 52'd0);
        chk("timeout bin_time",    bin_time,         E1);
        chk("timeout no set_time", 52'(n_sets),      52'(s0));
        chk("timeout blink",       52'(blink),       52'd0);

        // Asynchronous reset in the middle of an hour edit.
        cur_time = mk(2022, 7, 15, 8, 30, 45);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("hr edit before rst", bin_time, mk(2022, 7, 15, 9, 30, 45));
        chk("hr field before rst", 52'(edit_field), 52'd3);
        s0 = n_sets;
        #2 rst = 1'b1;
        #1;
        chk("rst edit_active", 52'(edit_active), 52'd0);
        chk("rst edit_field",  52'(edit_field),  52'd0);
        chk("rst bin_time",    bin_time,         R);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("after rst idle",      52'(edit_active), 52'd0);
        chk("after rst no set",    52'(n_sets),      52'(s0));
        chk("after rst bin_time",  bin_time,         R);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
